// File: rtl/shift_in_fifo_if.sv
// Handshake/data bundle between a shift_in_fifo and its user.
// The master side drives write/read requests and the write word; the
// slave side (the FIFO) returns the oldest word, occupancy and flags.
interface shift_in_fifo_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic [WIDTH-1:0] data_in;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output data_in, push, pop,
        input  data_out, full, empty, count, overflow, underflow
    );

    modport slave (
        input  data_in, push, pop,
        output data_out, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/shift_in_fifo.sv
// Write-side-shifting register FIFO.
// Every accepted push shifts all stages one place deeper and loads the new
// word at stage 0, so the write path only ever touches neighbouring stages.
// The oldest word sits at stage[count-1] and is picked by an occupancy-indexed
// mux; a pop only decrements the count and moves no data.
// DEPTH must be at least 2.
module shift_in_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 res,
    shift_in_fifo_if.slave       bus
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             underflow_q;
    logic             underflow_d;

    logic             is_full;
    logic             is_empty;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] data_out_mux;

    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);

    // A push is taken when there is room, or when a simultaneous pop frees
    // the slot (full case). A pop is taken only if something is stored; on
    // an empty FIFO a push+pop keeps the push and ignores the pop.
    assign do_pop  = bus.pop && !is_empty;
    assign do_push = bus.push && (!is_full || do_pop);

    // Shift network: stage 0 loads the new word, each deeper stage takes its
    // shallower neighbour. On a full push+pop the old deepest word (the one
    // being popped) simply falls off the end.
    assign stage_d[0] = do_push ? bus.data_in : stage_q[0];
    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
            assign stage_d[gi] = do_push ? stage_q[gi-1] : stage_q[gi];
        end
    endgenerate

    // Occupancy and sticky error flags next state.
    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
        if (bus.push && !do_push) begin
            overflow_d = 1'b1;
        end
        if (bus.pop && is_empty) begin
            underflow_d = 1'b1;
        end
    end

    // State registers; reset clears storage, count and both sticky flags and
    // takes priority over any request in the same cycle.
    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Read mux: expose stage[count-1]; an empty FIFO shows zeros so stale
    // stage contents never leak out.
    always_comb begin
        data_out_mux = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CW'(i + 1)) begin
                data_out_mux = stage_q[i];
            end
        end
    end

    assign bus.data_out  = data_out_mux;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: doc/shift_in_fifo.md
Name: shift_in_fifo

Overview:
- Write-side-shifting register FIFO, the mirror of the fill-at-first-empty / shift-on-read stage queue.
- Every push shifts all stages one position deeper and loads the new word at stage 0; the oldest word sits at the deepest filled stage and is read through an occupancy-indexed mux.
- Pops only decrement occupancy, so no data moves on read.
- Used where read-side timing is relaxed and write-side fanout must stay local.

Parameters:
- WIDTH, 32, data word width in bits
- DEPTH, 8, number of register stages; must be >= 2
- CW, $clog2(DEPTH+1), width of the occupancy count

Ports:
- clk  input  1  system clock, all state on rising edge
- res  input  1  synchronous reset, active-high
- data_in  input  WIDTH  word to write
- push  input  1  write request, sampled on rising clk
- full  output  1  high when count == DEPTH
- data_out  output  WIDTH  oldest word, i.e. stage[count-1]; all zeros when empty
- pop  input  1  read request; consumes data_out in the same cycle
- empty  output  1  high when count == 0
- count  output  CW  current occupancy, 0..DEPTH
- overflow  output  1  sticky; set by a push that is dropped
- underflow  output  1  sticky; set by a pop that is ignored

Behaviour:
- Reset is synchronous and active-high: on a rising clk with res=1, all stages <= 0, count <= 0, overflow <= 0, underflow <= 0. Reset overrides push and pop in the same cycle.
- Outputs after reset: empty=1, full=0, data_out=0, count=0.
- Storage: stage[0..DEPTH-1]. Stage contents beyond count-1 are don't-care but must never reach data_out.
- Accepted push: stage[0] <= data_in, and stage[i] <= stage[i-1] for i = 1..DEPTH-1.
- Decision table on {push, pop}, evaluated against state before the edge:
  - 00: hold everything.
  - 10, not full: shift in; count+1.
  - 10, full: no shift, count holds, overflow <= 1. Stored data is unchanged.
  - 01, not empty: count-1; stages untouched.
  - 01, empty: no change, underflow <= 1.
  - 11, 0 < count < DEPTH: shift in, count holds. The oldest word moves to index count and count stays, so the next oldest is correctly exposed at stage[count-1].
  - 11, full: shift in, count stays DEPTH. The old stage[DEPTH-1] (the word being popped) shifts out and is discarded. No overflow.
  - 11, empty: push accepted (count becomes 1), pop ignored, underflow <= 1.
- data_out, full, empty and count are combinational from registered state: zero-latency read. Push-to-visible latency is 1 cycle when the FIFO was empty.
- overflow and underflow are cleared only by reset.
- Count never exceeds DEPTH and never wraps below 0.

Test Plan:
- Reset then idle 3 cycles -> empty=1, full=0, count=0, data_out=0, overflow=0, underflow=0.
- Push 0x11, 0x22, 0x33 on consecutive cycles (DEPTH=8), then pop 3 times -> data_out reads 0x11, 0x22, 0x33 in order; count goes 3,2,1,0; empty=1 after the last pop.
- Push 0x01..0x08 to full, then push 0x99 alone -> full=1, count=8, overflow=1; subsequent pops return 0x01..0x08 and 0x99 never appears.
- Fill with 0x01..0x08, then assert push+pop with 0xA0, 0xA1 for two cycles -> count stays 8, overflow=0; draining yields 0x03..0x08, 0xA0, 0xA1.
- Push+pop on empty with data_in=0x55 -> count=1, data_out=0x55, underflow=1; a lone pop on empty leaves count=0 and underflow=1.
- Push 0x77 with res=1 in the same cycle while count=4 -> next cycle count=0, empty=1, data_out=0, both sticky flags 0.
